// File: rtl/pixel_scan_pkg.sv
// -----------------------------------------------------------------------------
// pixel_scan_pkg
// Shared definitions for the two-pass pixel scan sequencer:
//   - scan_state_e : sequencer state encoding
//   - N            : pixel count of the default-sized image
//   - scan_len()   : pixel count for an arbitrary image size
//   - is_read_state(): states in which the pixel memory is read
// -----------------------------------------------------------------------------
package pixel_scan_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PASS1   = 3'd1,
        WAIT_WE = 3'd2,
        PASS2   = 3'd3,
        DRAIN   = 3'd4,
        FINISH  = 3'd5
    } scan_state_e;

    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;
    localparam int N         = IMG_W_DEF * IMG_H_DEF;

    // Number of pixels visited by one pass over a w x h image.
    function automatic int scan_len(input int w, input int h);
        return w * h;
    endfunction

    // The address counter only advances (and rd_en is only high) in the two pass states.
    function automatic logic is_read_state(input scan_state_e s);
        return (s == PASS1) || (s == PASS2);
    endfunction

endpackage

// File: rtl/scan_addr_counter.sv
// -----------------------------------------------------------------------------
// scan_addr_counter
// Raster address counter for one pass over the image. Counts 0..N_PIX-1 while
// enabled and wraps to 0 after the last pixel, so it never presents an
// out-of-range address.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (higher priority than en)
//   en         : advance by one pixel
//   addr       : current (registered) address
//   tc         : terminal count, high while addr == N_PIX-1
// -----------------------------------------------------------------------------
module scan_addr_counter
    import pixel_scan_pkg::*;
#(
    parameter int N_PIX  = N,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              tc
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] count_d;

    assign tc   = (count_q == LAST_ADDR);
    assign addr = count_q;

    // Next count: clear, wrap at the last pixel, or step by one.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (tc) begin
                count_d = '0;
            end else begin
                count_d = count_q + ADDR_W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pixel_scan_sequencer.sv
// -----------------------------------------------------------------------------
// pixel_scan_sequencer
// Drives two raster passes over an IMG_W x IMG_H pixel memory. Pass 1 only
// reads; the block then waits (indefinitely) for the controller's we to
// acknowledge done. Pass 2 reads again and issues an output write for every
// pixel one cycle after its read (one-cycle memory latency), followed by a
// drain cycle for the last write. FINISH holds reallydone until a new start.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a two-pass scan (honoured only in IDLE / FINISH)
//   we          : controller acknowledge of done (honoured only in WAIT_WE)
//   rd_en       : pixel memory read strobe
//   rd_addr     : pixel memory read address
//   wr_valid    : output write strobe (pass 2 only)
//   wr_addr     : output write address (pass 2 only)
//   done        : level, pass 1 complete and awaiting we
//   reallydone  : level, pass 2 complete
//   pass        : 0 during pass 1, 1 during pass 2 (including the drain cycle)
// All outputs are registered.
// -----------------------------------------------------------------------------
module pixel_scan_sequencer
    import pixel_scan_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              we,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              done,
    output logic              reallydone,
    output logic              pass
);

    localparam int N_PIX = scan_len(IMG_W, IMG_H);

    scan_state_e       state_q;
    scan_state_e       state_d;

    logic              cnt_en_s;
    logic              cnt_clr_s;
    logic              cnt_tc_s;
    logic [ADDR_W-1:0] cnt_addr_s;

    logic              rd_en_q;
    logic              rd_en_d;
    logic              wr_valid_q;
    logic              wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] wr_addr_d;
    logic              done_q;
    logic              done_d;
    logic              reallydone_q;
    logic              reallydone_d;
    logic              pass_q;
    logic              pass_d;

    // The counter sits at 0 outside the pass states, so every pass starts at address 0.
    assign cnt_en_s  = is_read_state(state_q);
    assign cnt_clr_s = !cnt_en_s;

    scan_addr_counter #(
        .N_PIX  (N_PIX),
        .ADDR_W (ADDR_W)
    ) u_addr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .addr  (cnt_addr_s),
        .tc    (cnt_tc_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start and we are ignored outside the states that sample them.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = PASS1;
                else       state_d = IDLE;
            end
            PASS1: begin
                if (cnt_tc_s) state_d = WAIT_WE;
                else          state_d = PASS1;
            end
            WAIT_WE: begin
                if (we) state_d = PASS2;
                else    state_d = WAIT_WE;
            end
            PASS2: begin
                if (cnt_tc_s) state_d = DRAIN;
                else          state_d = PASS2;
            end
            DRAIN: begin
                state_d = FINISH;
            end
            FINISH: begin
                if (start) state_d = PASS1;
                else       state_d = FINISH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the flags change on the same edge as the state.
    // The write strobe is the pass-2 read strobe delayed one cycle.
    always_comb begin
        rd_en_d      = is_read_state(state_d);
        done_d       = (state_d == WAIT_WE);
        reallydone_d = (state_d == FINISH);
        pass_d       = (state_d == PASS2) || (state_d == DRAIN);
        wr_valid_d   = rd_en_q && pass_q;
        if (wr_valid_d) begin
            wr_addr_d = cnt_addr_s;
        end else begin
            wr_addr_d = '0;
        end
    end

    // Output and read-to-write delay registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q      <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            done_q       <= 1'b0;
            reallydone_q <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            rd_en_q      <= rd_en_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            done_q       <= done_d;
            reallydone_q <= reallydone_d;
            pass_q       <= pass_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr    = cnt_addr_s;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign done       = done_q;
    assign reallydone = reallydone_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pixel_scan_sequencer
// Directed bench for a 4x4 image (N = 16). Output vector compared each cycle:
//   {rd_en, rd_addr[3:0], wr_valid, wr_addr[3:0], done, reallydone, pass}
// -----------------------------------------------------------------------------
module tb_pixel_scan_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       we;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic       done;
    logic       reallydone;
    logic       pass;

    int errors;
    int checks;

    typedef struct {
        logic        start;
        logic        we;
        logic [12:0] exp;
    } vec_t;

    vec_t vq[$];

    logic [12:0] act;
    assign act = {rd_en, rd_addr, wr_valid, wr_addr, done, reallydone, pass};

    pixel_scan_sequencer #(
        .IMG_W  (4),
        .IMG_H  (4),
        .ADDR_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .we         (we),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .done       (done),
        .reallydone (reallydone),
        .pass       (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] mk(input logic rd, input logic [3:0] ra,
                                       input logic wv, input logic [3:0] wa,
                                       input logic dn, input logic rdn, input logic ps);
        return {rd, ra, wv, wa, dn, rdn, ps};
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b ({rd_en,rd_addr,wr_valid,wr_addr,done,reallydone,pass})",
                     name, got, exp);
        end
    endtask

    task automatic add(input logic s, input logic w, input logic [12:0] e);
        vec_t v;
        v.start = s;
        v.we    = w;
        v.exp   = e;
        vq.push_back(v);
    endtask

    // Each vector: inputs applied before a rising edge, outputs checked 1 time unit after it.
    task automatic run_vecs(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            start = vq[i].start;
            we    = vq[i].we;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, i), act, vq[i].exp);
        end
        vq.delete();
        start = 1'b0;
        we    = 1'b0;
    endtask

    // Global invariants sampled on every falling edge.
    always @(negedge clk) begin
        checks++;
        if ((done && reallydone) || (wr_valid && !pass)) begin
            errors++;
            $display("FAIL invariant: done=%b reallydone=%b wr_valid=%b pass=%b required no overlap",
                     done, reallydone, wr_valid, pass);
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        we     = 1'b0;

        #12;
        check("reset_values", act, 13'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset, then pass 1 with ignored start/we pulses, then done.
        add(1'b0, 1'b0, mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        add(1'b0, 1'b1, mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        add(1'b1, 1'b0, mk(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k < 16; k++) begin
            add(k == 5 || k == 15, k == 8, mk(1'b1, 4'(k), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        end
        add(1'b1, 1'b0, mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0));
        run_vecs("pass1");

        // Long wait for we with stray start pulses.
        for (int i = 0; i < 50; i++) begin
            start = (i % 7 == 0);
            we    = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("wait_we[%0d]", i), act, mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0));
        end
        start = 1'b0;

        // Pass 2, drain, finish, restart, then run up to pass 2 address 7.
        add(1'b0, 1'b1, mk(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
        for (int k = 1; k < 16; k++) begin
            add(k == 3, k == 9, mk(1'b1, 4'(k), 1'b1, 4'(k - 1), 1'b0, 1'b0, 1'b1));
        end
        add(1'b1, 1'b0, mk(1'b0, 4'd0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1));
        add(1'b1, 1'b1, mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));
        add(1'b0, 1'b1, mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));
        add(1'b1, 1'b0, mk(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k < 16; k++) begin
            add(1'b0, 1'b0, mk(1'b1, 4'(k), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        end
        add(1'b0, 1'b0, mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0));
        add(1'b0, 1'b1, mk(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
        for (int k = 1; k < 8; k++) begin
            add(1'b0, 1'b0, mk(1'b1, 4'(k), 1'b1, 4'(k - 1), 1'b0, 1'b0, 1'b1));
        end
        run_vecs("pass2");

        // Asynchronous reset in the middle of a cycle at pass 2 address 7.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", act, 13'd0);
        @(posedge clk);
        #1;
        check("reset_held", act, 13'd0);
        rst_n = 1'b1;

        add(1'b0, 1'b0, mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        add(1'b0, 1'b1, mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        add(1'b0, 1'b0, mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        add(1'b1, 1'b0, mk(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        add(1'b0, 1'b0, mk(1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        run_vecs("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_scan_sequencer.md
PIXEL_SCAN_SEQUENCER -- requirements
Module: pixel_scan_sequencer

Interface
REQ-001 Parameter IMG_W, default 256: image width in pixels.
REQ-002 Parameter IMG_H, default 256: image height in pixels.
REQ-003 Parameter ADDR_W, default 16: address width; SHALL satisfy 2^ADDR_W >= IMG_W*IMG_H.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request a two-pass scan; sampled only in IDLE or FINISH.
REQ-008 we  input  1  controller write enable; acknowledges done.
REQ-009 rd_en  output  1  pixel memory read strobe.
REQ-010 rd_addr  output  ADDR_W  pixel memory read address.
REQ-011 wr_valid  output  1  output-write strobe, pass 2 only.
REQ-012 wr_addr  output  ADDR_W  output-write address, pass 2 only.
REQ-013 done  output  1  first pass complete, level.
REQ-014 reallydone  output  1  second pass complete, level.
REQ-015 pass  output  1  0 during pass 1, 1 during pass 2.

Function
REQ-016 The block SHALL use states IDLE, PASS1, WAIT_WE, PASS2, DRAIN and FINISH; N = IMG_W*IMG_H.
REQ-017 IDLE: start=1 SHALL transition to PASS1 on the next edge with the address counter at 0.
REQ-018 PASS1: rd_en SHALL be 1 with rd_addr = 0..N-1 on N consecutive cycles, then the block SHALL enter WAIT_WE.
REQ-019 WAIT_WE: done SHALL be 1 and rd_en SHALL be 0; we=1 sampled SHALL transition to PASS2 with the counter at 0.
REQ-020 done SHALL drop to 0 on the same edge that enters PASS2, and SHALL never be 1 while reallydone is 1.
REQ-021 PASS2: rd_en SHALL be 1 with rd_addr = 0..N-1 on N cycles, pass=1, then the block SHALL enter DRAIN.
REQ-022 wr_valid/wr_addr SHALL equal rd_en/rd_addr of pass 2, delayed by exactly one cycle (1-cycle memory read latency).
REQ-023 DRAIN: one cycle carrying the final wr_valid (wr_addr=N-1), then the block SHALL enter FINISH.
REQ-024 FINISH: reallydone SHALL be 1 and all strobes SHALL be 0; start=1 SHALL clear reallydone and enter PASS1 at address 0.
REQ-025 start in PASS1, WAIT_WE, PASS2 or DRAIN SHALL be ignored; we outside WAIT_WE SHALL be ignored.
REQ-026 The address counter SHALL wrap to 0 after N-1 and SHALL never present an address >= N.
REQ-027 WAIT_WE has no timeout; the block SHALL hold done indefinitely until we=1.

Reset
REQ-028 rst_n=0 at any time, including mid-pass, SHALL immediately force IDLE, counter=0 and delay register=0.
REQ-029 Reset values: rd_en=0, rd_addr=0, wr_valid=0, wr_addr=0, done=0, reallydone=0, pass=0.
REQ-030 After rst_n releases, the block SHALL remain in IDLE until start=1.

Structure
REQ-031 The state enum and the localparam N SHALL live in the shared package pixel_scan_pkg.
REQ-032 The address counter with terminal-count flag SHALL be one sub-module, scan_addr_counter.

Verification (IMG_W=4, IMG_H=4, N=16)
REQ-033 Reset, start pulse -> rd_addr 0..15 with rd_en=1 on 16 cycles, then done=1 on the next cycle.
REQ-034 Hold we=0 for 50 cycles in WAIT_WE -> done stays 1 and rd_en stays 0; then we=1 -> PASS2, done=0 on the same edge.
REQ-035 Pass 2 -> wr_addr 0..15 on 16 cycles, each one cycle after the matching rd_addr; reallydone=1 the cycle after wr_addr=15.
REQ-036 start pulses during PASS1 and PASS2 -> no change in sequence; start in FINISH -> reallydone=0 and rd_addr=0 on the next cycle.
REQ-037 rst_n=0 at PASS2 rd_addr=7 -> all outputs 0 asynchronously; after release, a new start begins PASS1 at address 0.
REQ-038 Assertion over all tests: done and reallydone never both 1; wr_valid never 1 while pass=0.
